golden_nonce_tx: RTL and testbench

Serial return path for a miner node. Accepts single-cycle golden-nonce strobes from the hasher, holds them in a small FIFO, and sends each as four UART bytes (8N1, most-significant byte first) on TxD toward the hub or host. Sits directly downstream of the hasher core, in the same hash_clk domain, replacing any ad-hoc single-word transmitter. No nonce is lost while the FIFO has room; an overflow is flagged when one is dropped.

---
 rtl/golden_nonce_tx_if.sv | 21 ++
 rtl/golden_nonce_tx.sv | 158 +++++++++++++++
 tb/tb_golden_nonce_tx.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/golden_nonce_tx_if.sv
// Hasher-side nonce strobe plus UART line and queue status for golden_nonce_tx.
interface golden_nonce_tx_if #(
  parameter int FIFO_LOG2 = 2
);
  logic [31:0]        golden_nonce;
  logic               golden_nonce_valid;
  logic               TxD;
  logic               busy;
  logic               overflow;
  logic [FIFO_LOG2:0] pending;

  modport master (
    output golden_nonce, golden_nonce_valid,
    input  TxD, busy, overflow, pending
  );

  modport slave (
    input  golden_nonce, golden_nonce_valid,
    output TxD, busy, overflow, pending
  );
endinterface

// File: rtl/golden_nonce_tx.sv
// Queues golden-nonce strobes and sends each as 4 UART 8N1 bytes, MSB byte first; TxD starts 2 cycles after the strobe.
// No backpressure: a strobe into a full FIFO without a same-cycle pop is dropped and sets sticky overflow; NONCE_DEDUP_EN drops repeats.
module golden_nonce_tx #(
  parameter int BAUD_DIV  = 434,
  parameter int FIFO_LOG2 = 2
) (
  input logic              hash_clk,
  input logic              reset,
  golden_nonce_tx_if.slave nif
);
  localparam int                 DEPTH     = 1 << FIFO_LOG2;
  localparam logic [15:0]        BAUD_LAST = 16'(BAUD_DIV - 1);
  localparam logic [FIFO_LOG2:0] PTR_ONE   = {{FIFO_LOG2{1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t             state_q, state_d;
  logic [15:0]        baud_q, baud_d;
  logic [2:0]         bit_idx_q, bit_idx_d;
  logic [1:0]         byte_idx_q, byte_idx_d;
  logic [31:0]        shreg_q, shreg_d;
  logic               txd_q, txd_d;
  logic               overflow_q, overflow_d;
  logic [FIFO_LOG2:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_LOG2:0] rd_ptr_q, rd_ptr_d;
  logic [31:0]        mem_q [DEPTH];
  logic [31:0]        mem_d [DEPTH];

  logic       empty, full, pop, push, push_req, dup, baud_done;
  logic [7:0] cur_byte;

`ifdef NONCE_DEDUP_EN
  // Separate valid bit so that nonce 0 is not mistaken for a repeat after reset.
  logic [31:0] last_q, last_d;
  logic        last_vld_q, last_vld_d;

  always_comb begin
    last_d     = last_q;
    last_vld_d = last_vld_q;
    if (push) begin
      last_d     = nif.golden_nonce;
      last_vld_d = 1'b1;
    end
  end

  always_ff @(posedge hash_clk or posedge reset) begin
    if (reset) begin
      last_q     <= '0;
      last_vld_q <= 1'b0;
    end else begin
      last_q     <= last_d;
      last_vld_q <= last_vld_d;
    end
  end

  assign dup = last_vld_q && (nif.golden_nonce == last_q);
`else
  assign dup = 1'b0;
`endif

  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[FIFO_LOG2] != rd_ptr_q[FIFO_LOG2]) &&
               (wr_ptr_q[FIFO_LOG2-1:0] == rd_ptr_q[FIFO_LOG2-1:0]);
    pop      = (state_q == IDLE) && !empty;
    push_req = nif.golden_nonce_valid && !dup;
    // A pop in the same cycle frees the slot the incoming word needs.
    push     = push_req && (!full || pop);

    wr_ptr_d   = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    overflow_d = overflow_q | (push_req && full && !pop);

    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q[FIFO_LOG2-1:0]] = nif.golden_nonce;
  end

  always_comb begin
    baud_done  = (baud_q == BAUD_LAST);
    cur_byte   = shreg_q[31:24];
    state_d    = state_q;
    baud_d     = baud_done ? 16'd0 : baud_q + 16'd1;
    bit_idx_d  = bit_idx_q;
    byte_idx_d = byte_idx_q;
    shreg_d    = shreg_q;
    txd_d      = 1'b1;

    case (state_q)
      IDLE: begin
        baud_d = 16'd0;
        if (pop) begin
          shreg_d    = mem_q[rd_ptr_q[FIFO_LOG2-1:0]];
          byte_idx_d = 2'd0;
          state_d    = START;
        end
      end
      START: begin
        txd_d = 1'b0;
        if (baud_done) begin
          bit_idx_d = 3'd0;
          state_d   = DATA;
        end
      end
      DATA: begin
        txd_d = cur_byte[bit_idx_q];
        if (baud_done) begin
          if (bit_idx_q == 3'd7) state_d = STOP;
          else                   bit_idx_d = bit_idx_q + 3'd1;
        end
      end
      STOP: begin
        txd_d = 1'b1;
        if (baud_done) begin
          if (byte_idx_q != 2'd3) begin
            byte_idx_d = byte_idx_q + 2'd1;
            shreg_d    = {shreg_q[23:0], 8'h00};
            state_d    = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // TxD is registered from the current state, so the line lags the FSM by one cycle.
  always_ff @(posedge hash_clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      baud_q     <= '0;
      bit_idx_q  <= '0;
      byte_idx_q <= '0;
      shreg_q    <= '0;
      txd_q      <= 1'b1;
      overflow_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_idx_q  <= bit_idx_d;
      byte_idx_q <= byte_idx_d;
      shreg_q    <= shreg_d;
      txd_q      <= txd_d;
      overflow_q <= overflow_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      mem_q      <= mem_d;
    end
  end

  assign nif.TxD      = txd_q;
  assign nif.overflow = overflow_q;
  assign nif.pending  = wr_ptr_q - rd_ptr_q;
  assign nif.busy     = (state_q != IDLE) || (wr_ptr_q != rd_ptr_q);
endmodule

// File: tb/tb_golden_nonce_tx.sv
// Directed bench for golden_nonce_tx: a BAUD_DIV=4 instance with a UART decoder and a BAUD_DIV=2 instance checked cycle by cycle.
module tb_golden_nonce_tx;
  localparam int BD_A = 4;
  localparam int BD_B = 2;
  localparam int FL   = 2;

  logic hash_clk = 1'b0;
  logic reset    = 1'b1;
  always #5 hash_clk = ~hash_clk;

  golden_nonce_tx_if #(.FIFO_LOG2(FL)) nif_a ();
  golden_nonce_tx_if #(.FIFO_LOG2(FL)) nif_b ();

  golden_nonce_tx #(.BAUD_DIV(BD_A), .FIFO_LOG2(FL)) dut_a (
    .hash_clk(hash_clk), .reset(reset), .nif(nif_a)
  );
  golden_nonce_tx #(.BAUD_DIV(BD_B), .FIFO_LOG2(FL)) dut_b (
    .hash_clk(hash_clk), .reset(reset), .nif(nif_b)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] rx_q[$];
  int          rx_ferr = 0;
  bit          rx_act;
  int          rx_cnt;
  int          rx_nb;
  logic [7:0]  rx_byte;
  logic [31:0] rx_word;

  // UART decoder on instance A: sample mid-cell on falling clock edges.
  initial begin
    int k;
    rx_act  = 1'b0;
    rx_cnt  = 0;
    rx_nb   = 0;
    rx_byte = '0;
    rx_word = '0;
    forever begin
      @(negedge hash_clk);
      if (reset) begin
        rx_act = 1'b0;
        rx_nb  = 0;
      end else if (!rx_act) begin
        if (nif_a.TxD === 1'b0) begin
          rx_act = 1'b1;
          rx_cnt = 0;
        end
      end else begin
        rx_cnt++;
        if (rx_cnt % BD_A == BD_A / 2) begin
          k = rx_cnt / BD_A;
          if (k >= 1 && k <= 8) rx_byte[k-1] = nif_a.TxD;
          else if (k == 9) begin
            if (nif_a.TxD !== 1'b1) rx_ferr++;
            rx_word = {rx_word[23:0], rx_byte};
            rx_nb++;
            if (rx_nb == 4) begin
              rx_q.push_back(rx_word);
              rx_nb = 0;
            end
            rx_act = 1'b0;
          end
        end
      end
    end
  end

  function automatic logic frame_bit(input logic [31:0] w, input int c, input int bd);
    int         bi;
    int         k;
    logic [7:0] b;
    bi = c / (10 * bd);
    k  = (c % (10 * bd)) / bd;
    b  = 8'(w >> (8 * (3 - bi)));
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return b[k-1];
  endfunction

  task automatic drive_burst(input logic [31:0] base, input int n);
    @(posedge hash_clk);
    #1;
    for (int i = 0; i < n; i++) begin
      nif_a.golden_nonce       = base + 32'(i);
      nif_a.golden_nonce_valid = 1'b1;
      @(posedge hash_clk);
      #1;
    end
    nif_a.golden_nonce_valid = 1'b0;
  endtask

  task automatic wait_idle_a(input int maxc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge hash_clk);
      if (!nif_a.busy) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (4) @(negedge hash_clk);
  endtask

  task automatic test_reset;
    #12;
    n_tests++; if (nif_a.TxD !== 1'b1) begin n_fail++; $display("FAIL reset_txd: got %b want 1", nif_a.TxD); end
    n_tests++; if (nif_a.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", nif_a.busy); end
    n_tests++; if (nif_a.overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b want 0", nif_a.overflow); end
    n_tests++; if (nif_a.pending !== 3'd0) begin n_fail++; $display("FAIL reset_pending: got %0d want 0", nif_a.pending); end
    n_tests++; if (nif_b.TxD !== 1'b1 || nif_b.pending !== 3'd0) begin n_fail++; $display("FAIL reset_b: txd %b pending %0d want 1/0", nif_b.TxD, nif_b.pending); end
    @(negedge hash_clk);
    reset = 1'b0;
    repeat (2) @(negedge hash_clk);
  endtask

  task automatic test_single_frame;
    int errs;
    int first_bad;
    errs      = 0;
    first_bad = -1;
    rx_q.delete();
    drive_burst(32'hDEADBEEF, 1);
    @(negedge hash_clk);
    n_tests++; if (nif_a.TxD !== 1'b1 || nif_a.busy !== 1'b1) begin n_fail++; $display("FAIL single_pre1: txd %b busy %b want 1/1", nif_a.TxD, nif_a.busy); end
    @(negedge hash_clk);
    n_tests++; if (nif_a.TxD !== 1'b1) begin n_fail++; $display("FAIL single_pre2: txd %b want 1 (falls one cycle later)", nif_a.TxD); end
    for (int c = 0; c < 40 * BD_A; c++) begin
      @(negedge hash_clk);
      if (nif_a.TxD !== frame_bit(32'hDEADBEEF, c, BD_A)) begin
        errs++;
        if (first_bad < 0) first_bad = c;
      end
    end
    n_tests++; if (errs != 0) begin n_fail++; $display("FAIL single_wave: %0d bad cycles, first at %0d, want 0", errs, first_bad); end
    @(negedge hash_clk);
    n_tests++; if (nif_a.TxD !== 1'b1 || nif_a.busy !== 1'b0) begin n_fail++; $display("FAIL single_end: txd %b busy %b want 1/0", nif_a.TxD, nif_a.busy); end
    n_tests++; if (rx_q.size() != 1 || rx_q[0] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_rx: size %0d first %h want 1/deadbeef", rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 32'h0); end
  endtask

  task automatic test_fifo_fill;
    bit ok;
    rx_q.delete();
    drive_burst(32'h1, 5);
    wait_idle_a(2000, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL fill_timeout: busy %b want 0", nif_a.busy); end
    n_tests++; if (rx_q.size() != 5) begin n_fail++; $display("FAIL fill_count: got %0d want 5", rx_q.size()); end
    for (int i = 0; i < 5 && i < rx_q.size(); i++) begin
      n_tests++; if (rx_q[i] !== 32'(i + 1)) begin n_fail++; $display("FAIL fill_word%0d: got %h want %h", i, rx_q[i], 32'(i + 1)); end
    end
    n_tests++; if (nif_a.overflow !== 1'b0) begin n_fail++; $display("FAIL fill_overflow: got %b want 0", nif_a.overflow); end
  endtask

  task automatic test_full_pop;
    bit ok;
    rx_q.delete();
    drive_burst(32'h21, 5);
    @(negedge hash_clk);
    n_tests++; if (nif_a.pending !== 3'd4) begin n_fail++; $display("FAIL fullpop_fill: pending %0d want 4", nif_a.pending); end
    repeat (157) @(posedge hash_clk);
    #1;
    n_tests++; if (nif_a.pending !== 3'd4) begin n_fail++; $display("FAIL fullpop_before: pending %0d want 4", nif_a.pending); end
    nif_a.golden_nonce       = 32'h26;
    nif_a.golden_nonce_valid = 1'b1;
    @(posedge hash_clk);
    #1;
    nif_a.golden_nonce_valid = 1'b0;
    @(negedge hash_clk);
    n_tests++; if (nif_a.pending !== 3'd4) begin n_fail++; $display("FAIL fullpop_pending: got %0d want 4", nif_a.pending); end
    n_tests++; if (nif_a.overflow !== 1'b0) begin n_fail++; $display("FAIL fullpop_overflow: got %b want 0", nif_a.overflow); end
    wait_idle_a(2000, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL fullpop_timeout: busy %b want 0", nif_a.busy); end
    n_tests++; if (rx_q.size() != 6) begin n_fail++; $display("FAIL fullpop_count: got %0d want 6", rx_q.size()); end
    for (int i = 0; i < 6 && i < rx_q.size(); i++) begin
      n_tests++; if (rx_q[i] !== 32'(32'h21 + i)) begin n_fail++; $display("FAIL fullpop_word%0d: got %h want %h", i, rx_q[i], 32'(32'h21 + i)); end
    end
  endtask

  task automatic test_overflow;
    bit ok;
    rx_q.delete();
    drive_burst(32'h11, 6);
    @(negedge hash_clk);
    n_tests++; if (nif_a.overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b want 1", nif_a.overflow); end
    n_tests++; if (nif_a.pending !== 3'd4) begin n_fail++; $display("FAIL ovf_pending: got %0d want 4", nif_a.pending); end
    wait_idle_a(2000, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL ovf_timeout: busy %b want 0", nif_a.busy); end
    n_tests++; if (rx_q.size() != 5) begin n_fail++; $display("FAIL ovf_count: got %0d want 5", rx_q.size()); end
    for (int i = 0; i < 5 && i < rx_q.size(); i++) begin
      n_tests++; if (rx_q[i] !== 32'(32'h11 + i)) begin n_fail++; $display("FAIL ovf_word%0d: got %h want %h", i, rx_q[i], 32'(32'h11 + i)); end
    end
    n_tests++; if (nif_a.overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b want 1", nif_a.overflow); end
  endtask

  task automatic test_reset_mid_frame;
    bit ok;
    rx_q.delete();
    drive_burst(32'h11220044, 3);
    repeat (90) @(posedge hash_clk);
    #2;
    n_tests++; if (nif_a.TxD !== 1'b0 || nif_a.pending !== 3'd2) begin n_fail++; $display("FAIL midrst_pre: txd %b pending %0d want 0/2", nif_a.TxD, nif_a.pending); end
    reset = 1'b1;
    #1;
    n_tests++; if (nif_a.TxD !== 1'b1) begin n_fail++; $display("FAIL midrst_txd: got %b want 1", nif_a.TxD); end
    n_tests++; if (nif_a.pending !== 3'd0 || nif_a.busy !== 1'b0) begin n_fail++; $display("FAIL midrst_state: pending %0d busy %b want 0/0", nif_a.pending, nif_a.busy); end
    n_tests++; if (nif_a.overflow !== 1'b0) begin n_fail++; $display("FAIL midrst_overflow: got %b want 0", nif_a.overflow); end
    repeat (2) @(negedge hash_clk);
    #1;
    reset = 1'b0;
    repeat (2) @(negedge hash_clk);
    rx_q.delete();
    drive_burst(32'h00000001, 1);
    wait_idle_a(1000, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL midrst_timeout: busy %b want 0", nif_a.busy); end
    n_tests++; if (rx_q.size() != 1 || rx_q[0] !== 32'h1) begin n_fail++; $display("FAIL midrst_rx: size %0d first %h want 1/00000001", rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 32'hx); end
  endtask

  task automatic test_dedup;
    bit          ok;
    logic [31:0] vals [3];
    logic [31:0] exp_w[$];
    vals = '{32'h12345678, 32'h12345678, 32'h00000000};
`ifdef NONCE_DEDUP_EN
    exp_w = '{32'h12345678, 32'h00000000};
`else
    exp_w = '{32'h12345678, 32'h12345678, 32'h00000000};
`endif
    rx_q.delete();
    @(posedge hash_clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      nif_a.golden_nonce       = vals[i];
      nif_a.golden_nonce_valid = 1'b1;
      @(posedge hash_clk);
      #1;
    end
    nif_a.golden_nonce_valid = 1'b0;
    wait_idle_a(2000, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL dedup_timeout: busy %b want 0", nif_a.busy); end
    n_tests++; if (rx_q.size() != exp_w.size()) begin n_fail++; $display("FAIL dedup_count: got %0d want %0d", rx_q.size(), exp_w.size()); end
    for (int i = 0; i < exp_w.size() && i < rx_q.size(); i++) begin
      n_tests++; if (rx_q[i] !== exp_w[i]) begin n_fail++; $display("FAIL dedup_word%0d: got %h want %h", i, rx_q[i], exp_w[i]); end
    end
    n_tests++; if (nif_a.overflow !== 1'b0 || rx_ferr != 0) begin n_fail++; $display("FAIL dedup_flags: overflow %b stop_errs %0d want 0/0", nif_a.overflow, rx_ferr); end
  endtask

  task automatic test_back_to_back;
    int errs1;
    int errs2;
    logic [31:0] w0;
    logic [31:0] w1;
    errs1 = 0;
    errs2 = 0;
    w0    = 32'hA53C0F81;
    w1    = 32'h5AC3F07E;
    @(posedge hash_clk);
    #1;
    nif_b.golden_nonce       = w0;
    nif_b.golden_nonce_valid = 1'b1;
    @(posedge hash_clk);
    #1;
    nif_b.golden_nonce       = w1;
    @(posedge hash_clk);
    #1;
    nif_b.golden_nonce_valid = 1'b0;
    @(negedge hash_clk);
    n_tests++; if (nif_b.TxD !== 1'b1) begin n_fail++; $display("FAIL b2b_pre: txd %b want 1", nif_b.TxD); end
    for (int c = 0; c < 80; c++) begin
      @(negedge hash_clk);
      if (nif_b.TxD !== frame_bit(w0, c, BD_B)) errs1++;
    end
    n_tests++; if (errs1 != 0) begin n_fail++; $display("FAIL b2b_frame1: %0d bad cycles want 0", errs1); end
    @(negedge hash_clk);
    n_tests++; if (nif_b.TxD !== 1'b1 || nif_b.busy !== 1'b1) begin n_fail++; $display("FAIL b2b_gap: txd %b busy %b want 1/1", nif_b.TxD, nif_b.busy); end
    for (int c = 0; c < 80; c++) begin
      @(negedge hash_clk);
      if (nif_b.TxD !== frame_bit(w1, c, BD_B)) errs2++;
    end
    n_tests++; if (errs2 != 0) begin n_fail++; $display("FAIL b2b_frame2: %0d bad cycles want 0", errs2); end
    @(negedge hash_clk);
    n_tests++; if (nif_b.TxD !== 1'b1 || nif_b.busy !== 1'b0) begin n_fail++; $display("FAIL b2b_end: txd %b busy %b want 1/0", nif_b.TxD, nif_b.busy); end
  endtask

  initial begin
    nif_a.golden_nonce       = '0;
    nif_a.golden_nonce_valid = 1'b0;
    nif_b.golden_nonce       = '0;
    nif_b.golden_nonce_valid = 1'b0;
    test_reset();
    test_single_frame();
    test_fifo_fill();
    test_full_pop();
    test_overflow();
    test_reset_mid_frame();
    test_dedup();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
